uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between NUM_REQ byte-producing requesters (e.g. CPU FIFO, debug port, DMA). Fair round-robin arbitration, one frame at a time. Drives uart_tx tx_start/din and consumes its tx_done. Sits between requesters and uart_tx inside the UART subsystem.

Parameters:
NUM_REQ, 4, number of requesters (>=2; need not be a power of two)
DATA_BITS, 8, width of each data word; matches the uart_tx DATA_BITS
TIMEOUT_CYC, 65535, clock cycles allowed in WAIT before abort (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
arb_en  in  1  when low, no new grants; an in-flight frame completes normally
req_valid  in  NUM_REQ  requester i has a word; held with its data until req_ready[i]
req_data  in  NUM_REQ*DATA_BITS  word of requester i at bits [i*DATA_BITS +: DATA_BITS]
req_ready  out  NUM_REQ  one-cycle pulse; word of requester i accepted this cycle
req_done  out  NUM_REQ  one-cycle pulse; frame of requester i finished on the line
tx_start  out  1  to uart_tx; one-cycle pulse
tx_din  out  DATA_BITS  to uart_tx din; registered, stable from the tx_start cycle until the next grant
tx_done  in  1  from uart_tx; one-cycle completion pulse
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
busy  out  1  high in START and WAIT
timeout_err  out  1  one-cycle pulse on watchdog abort; tied 0 without the optional feature

Behaviour:
- Reset values: state=IDLE, ptr=NUM_REQ-1 (requester 0 wins first), grant_id=0, tx_din=0, all other outputs 0.
- FSM states:
  - IDLE: if arb_en and any req_valid, pick the winner and go to START. Search order is ptr+1, ptr+2, ... mod NUM_REQ; the first valid requester wins.
  - Acceptance cycle: req_ready[winner]=1 (combinational from state, pick and arb_en). The same edge captures req_data of the winner into tx_din and the winner into grant_id.
  - START: tx_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: on tx_done, req_done[grant_id] pulses on the next cycle (registered), ptr<=grant_id, state returns to IDLE.
- Latency: req_valid seen in IDLE at cycle N -> req_ready at N -> tx_start at N+1.
- Back-to-back: after tx_done, the earliest next tx_start is 2 cycles later (IDLE, START). This lets uart_tx be back in its idle state before it sees tx_start.
- tx_done in IDLE or START is ignored; no req_done is generated.
- At most one req_ready bit is high per cycle; none is high outside IDLE.
- Requester deasserting req_valid before ready: the word is dropped from arbitration; no error.
- arb_en low in WAIT: the current frame finishes and req_done is still issued.
- Reset mid-frame: all state returns to reset values immediately. The pending requester gets no req_done and must re-request.
- Pointer wrap: the comparison-based modulo works for non-power-of-two NUM_REQ.

Optional Feature:
Macro: UART_TX_ARB_WATCHDOG_EN
- Defined: a counter clears on entry to WAIT and increments each cycle in WAIT. If it reaches TIMEOUT_CYC-1 without tx_done:
  - timeout_err pulses for one cycle
  - state goes to IDLE and ptr<=grant_id
  - no req_done is issued
  - tx_done arriving on that same cycle takes priority (normal completion)
- Undefined: no counter, timeout_err tied 0, WAIT waits indefinitely.

Decomposition:
- Package uart_arb_pkg:
  - arb_state_t enum {IDLE, START, WAIT}
  - grant-width localparam helper based on $clog2
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: valid vector, ptr.
  - Outputs: found flag, winner index.
  - Reusable by other arbiters.

Test Plan:
1. Single requester: req_valid=4'b0001, data 8'hA5 -> req_ready[0] same cycle, tx_start next cycle with tx_din=A5; tx_done stub -> req_done[0] one cycle later.
2. All four requesters valid continuously -> grant order 0,1,2,3,0; each grant is exactly one frame; req_ready is one-hot.
3. Requesters 1 and 3 valid after a frame from requester 2 -> requester 3 wins, then 1.
4. arb_en=0 while requester 0 is valid -> no req_ready. Deassert arb_en during WAIT -> frame still completes with req_done.
5. Assert reset_n low during WAIT -> all outputs 0 on the same cycle. After release, requester 0 wins first.
6. Watchdog (macro defined, TIMEOUT_CYC=20): suppress tx_done -> timeout_err after 20 cycles in WAIT, no req_done, next grant proceeds. Run again with tx_done on cycle 20 -> req_done issued, no timeout_err.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and helpers for the UART transmit arbiter.
//   arb_state_t : arbiter FSM state encoding
//   grant_w()   : width of a requester index for n requesters (min 1 bit)
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int ARB_STATE_W = 2;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches i_ptr+1, i_ptr+2, ... modulo N
// and reports the first set bit of i_valid. Works for any N >= 2, including
// non-power-of-two, because the wrap is done by compare-and-subtract.
// Ports:
//   i_valid  [N]   request vector
//   i_ptr    [IW]  last served index (must be < N)
//   o_found        at least one request is set
//   o_winner [IW]  index of the winning request (0 when o_found is low)
// ---------------------------------------------------------------------------
module rr_pick import uart_arb_pkg::*; #(
    parameter int N  = 4,
    parameter int IW = grant_w(N)
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_winner
);

    logic [31:0] w_idx;

    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = 32'(i_ptr) + 32'(k);
            if (w_idx >= 32'(N)) begin
                w_idx = w_idx - 32'(N);
            end
            if (!o_found && i_valid[w_idx[IW-1:0]]) begin
                o_found  = 1'b1;
                o_winner = w_idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx between NUM_REQ requesters, one frame at a time, with
// round-robin fairness.
//
//   state | meaning
//   IDLE  | no frame in flight; accept the round-robin winner when arb_en
//   START | tx_start pulse to uart_tx, tx_din already holds the word
//   WAIT  | frame on the line; wait for tx_done (or watchdog expiry)
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   arb_en               gate for new grants (in-flight frame always finishes)
//   req_valid/req_data   per-requester word, held until req_ready
//   req_ready            1-cycle accept pulse (combinational, IDLE only)
//   req_done             1-cycle frame-finished pulse (registered)
//   tx_start/tx_din      to uart_tx
//   tx_done              from uart_tx
//   grant_id             current or last granted requester
//   busy                 high in START and WAIT
//   timeout_err          1-cycle watchdog abort pulse
// Build option:
//   UART_TX_ARB_WATCHDOG_EN  enables the WAIT watchdog (TIMEOUT_CYC); when
//                            undefined timeout_err is tied 0 and WAIT waits
//                            indefinitely.
// ---------------------------------------------------------------------------
module uart_tx_arbiter import uart_arb_pkg::*; #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BITS   = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           arb_en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             req_done,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_din,
    input  logic                           tx_done,
    output logic [grant_w(NUM_REQ)-1:0]    grant_id,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int GW = grant_w(NUM_REQ);

    arb_state_t             r_state;
    logic [GW-1:0]          r_ptr;
    logic [GW-1:0]          r_grant_id;
    logic [DATA_BITS-1:0]   r_tx_din;
    logic [NUM_REQ-1:0]     r_req_done;

    logic                   w_found;
    logic [GW-1:0]          w_pick;
    logic                   w_accept;
    logic                   w_wd_expire;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_rr_pick (
        .i_valid  (req_valid),
        .i_ptr    (r_ptr),
        .o_found  (w_found),
        .o_winner (w_pick)
    );

    assign w_accept = (r_state == IDLE) && arb_en && w_found;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_pick] = 1'b1;
        end
    end

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_wd_cnt;
    logic          r_timeout_err;

    // tx_done on the expiry cycle wins, so it masks the abort.
    assign w_wd_expire = (r_state == WAIT) && !tx_done &&
                         (r_wd_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_wd_expire;
            if (r_state != WAIT) begin
                r_wd_cnt <= '0;
            end else if (!w_wd_expire) begin
                r_wd_cnt <= r_wd_cnt + CW'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYC;
    assign w_wd_expire      = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_ptr      <= GW'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_tx_din   <= '0;
            r_req_done <= '0;
        end else begin
            r_req_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tx_din   <= req_data[w_pick*DATA_BITS +: DATA_BITS];
                        r_grant_id <= w_pick;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        r_req_done[r_grant_id] <= 1'b1;
                        r_ptr                  <= r_grant_id;
                        r_state                <= IDLE;
                    end else if (w_wd_expire) begin
                        r_ptr   <= r_grant_id;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_start = (r_state == START);
    assign busy     = (r_state != IDLE);
    assign tx_din   = r_tx_din;
    assign grant_id = r_grant_id;
    assign req_done = r_req_done;

endmodule
